// File: rtl/rr_stream_mux.sv
// Registered N-to-1 stream multiplexer with round-robin arbitration over valid/ready channels.
// Optional macro RR_STREAM_MUX_FORCE_EN adds force_en/force_sel for legacy direct-select operation.
module rr_stream_mux #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int CW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [CW-1:0]   out_ch,
  input  logic            out_ready
`ifdef RR_STREAM_MUX_FORCE_EN
  ,
  input  logic            force_en,
  input  logic [CW-1:0]   force_sel
`endif
);

  // Handshake: a channel transfers on a rising edge where in_valid[i] && in_ready[i];
  // the output word is consumed on a rising edge where out_valid && out_ready.

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [CW-1:0] out_ch_q, out_ch_d;
  logic [CW-1:0] ptr_q, ptr_d;

  logic          load;
  logic          rr_found;
  logic [CW-1:0] rr_idx;
  logic          gnt_req;
  logic          ready_hit;
  logic          upd_ptr;
  logic [CW-1:0] gnt_idx;
  logic [N-1:0]  valid_sh;
  int            cand;

  assign load = !out_valid_q || out_ready;

  // Search ptr+1, ptr+2, ... in int arithmetic so the modulo never overruns CW bits.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    valid_sh = '0;
    for (int k = 1; k <= N; k++) begin
      cand     = (int'(ptr_q) + k) % N;
      valid_sh = in_valid >> cand;
      if (!rr_found && valid_sh[0]) begin
        rr_found = 1'b1;
        rr_idx   = CW'(cand);
      end
    end
  end

  always_comb begin
    gnt_idx   = rr_idx;
    gnt_req   = rr_found;
    ready_hit = rr_found;
    upd_ptr   = 1'b1;
`ifdef RR_STREAM_MUX_FORCE_EN
    if (force_en) begin
      // Forced grants leave ptr alone so round-robin resumes where it left off.
      gnt_idx   = force_sel;
      ready_hit = (int'(force_sel) < N);
      gnt_req   = ready_hit && ((in_valid >> force_sel) & N'(1)) != '0;
      upd_ptr   = 1'b0;
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && load && ready_hit) begin
      in_ready = N'(1) << gnt_idx;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (gnt_req) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data[int'(gnt_idx)*W +: W];
        out_ch_d    = gnt_idx;
        if (upd_ptr) begin
          ptr_d = gnt_idx;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= CW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: a 4x8 instance and a 5x16 (non-power-of-2) instance.
module tb_rr_stream_mux;

  logic         clk;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [31:0]  in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [1:0]   out_ch;
  logic         out_ready;

  logic         rst5_n;
  logic [4:0]   in_valid5;
  logic [79:0]  in_data5;
  logic [4:0]   in_ready5;
  logic         out_valid5;
  logic [15:0]  out_data5;
  logic [2:0]   out_ch5;
  logic         out_ready5;

  int vectors;
  int miscompares;

  rr_stream_mux #(.N(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .out_ready(out_ready)
  );

  rr_stream_mux #(.N(5), .W(16)) dut5 (
    .clk(clk), .rst_n(rst5_n), .in_valid(in_valid5), .in_data(in_data5),
    .in_ready(in_ready5), .out_valid(out_valid5), .out_data(out_data5),
    .out_ch(out_ch5), .out_ready(out_ready5)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          exp_ch[5]   = '{0, 1, 2, 3, 0};
  logic [3:0]  exp_rdy[5]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  int          sp_ch[4]    = '{1, 3, 1, 3};
  logic [3:0]  sp_rdy[4]   = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
  int          n5_ch[6]    = '{0, 1, 2, 3, 4, 0};
  logic [4:0]  n5_rdy[6]   = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00010};

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    rst5_n      = 1'b0;
    out_ready   = 1'b0;
    out_ready5  = 1'b1;
    in_valid    = 4'b1111;
    in_valid5   = 5'b11111;
    for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
    for (int i = 0; i < 5; i++) in_data5[i*16 +: 16] = 16'hB000 + 16'(i);

    // Reset with all channels requesting
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_ch",    32'(out_ch),    32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);

    rst_n     = 1'b1;
    out_ready = 1'b1;
    settle();
    check("first_in_ready", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_out_valid", 32'(out_valid), 32'd1);
      check("rr_out_ch",    32'(out_ch),    32'(exp_ch[i]));
      check("rr_out_data",  32'(out_data),  32'h10 + 32'(exp_ch[i]));
      check("rr_in_ready",  32'(in_ready),  32'(exp_rdy[i]));
    end

    // Sparse requests 1010
    in_valid = 4'b1010;
    settle();
    check("sp_in_ready0", 32'(in_ready), 32'b0010);
    for (int i = 0; i < 4; i++) begin
      step();
      check("sp_out_ch",   32'(out_ch),   32'(sp_ch[i]));
      check("sp_in_ready", 32'(in_ready), 32'(sp_rdy[i]));
    end

    // Backpressure
    in_valid = 4'b0100;
    in_data[2*8 +: 8] = 8'hA5;
    settle();
    check("bp_in_ready0", 32'(in_ready), 32'b0100);
    step();
    check("bp_out_data", 32'(out_data), 32'hA5);
    check("bp_out_ch",   32'(out_ch),   32'd2);
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    settle();
    check("bp_in_ready_hold", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_data",  32'(out_data),  32'hA5);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    settle();
    check("bp_release_ready", 32'(in_ready), 32'b0001);
    step();
    check("bp_refill_ch",    32'(out_ch),    32'd0);
    check("bp_refill_data",  32'(out_data),  32'h10);
    check("bp_refill_valid", 32'(out_valid), 32'd1);

    // Idle drain
    in_data[7:0] = 8'h3C;
    settle();
    check("dr_in_ready", 32'(in_ready), 32'b0001);
    step();
    check("dr_data",  32'(out_data),  32'h3C);
    check("dr_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b0000;
    settle();
    check("dr_in_ready_idle", 32'(in_ready), 32'd0);
    step();
    check("dr_valid_low", 32'(out_valid), 32'd0);
    check("dr_data_hold", 32'(out_data),  32'h3C);
    check("dr_ch_hold",   32'(out_ch),    32'd0);
    step();
    check("dr_valid_low2", 32'(out_valid), 32'd0);

    // Reset mid-operation discards the held word and restores the pointer
    in_valid = 4'b1111;
    step();
    check("mr_pre_ch",    32'(out_ch),    32'd1);
    check("mr_pre_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    rst_n     = 1'b0;
    settle();
    check("mr_valid",    32'(out_valid), 32'd0);
    check("mr_ch",       32'(out_ch),    32'd0);
    check("mr_data",     32'(out_data),  32'd0);
    check("mr_in_ready", 32'(in_ready),  32'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    settle();
    check("mr_first_ready", 32'(in_ready), 32'b0001);
    step();
    check("mr_first_ch", 32'(out_ch), 32'd0);

    // Non-power-of-2 instance: N=5, W=16
    rst5_n = 1'b1;
    settle();
    check("n5_first_ready", 32'(in_ready5), 32'b00001);
    for (int i = 0; i < 6; i++) begin
      step();
      check("n5_out_ch",    32'(out_ch5),    32'(n5_ch[i]));
      check("n5_out_data",  32'(out_data5),  32'hB000 + 32'(n5_ch[i]));
      check("n5_in_ready",  32'(in_ready5),  32'(n5_rdy[i]));
    end
    in_valid5 = 5'b10001;
    settle();
    check("n5_wrap_ready0", 32'(in_ready5), 32'b10000);
    step();
    check("n5_wrap_ch4",    32'(out_ch5),   32'd4);
    check("n5_wrap_ready1", 32'(in_ready5), 32'b00001);
    step();
    check("n5_wrap_ch0",    32'(out_ch5),   32'd0);
    check("n5_wrap_ready2", 32'(in_ready5), 32'b10000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised, registered N-to-1 stream multiplexer with round-robin arbitration.
- Successor to the 4:1 select-driven mux: N channels of W bits, each with a valid/ready handshake.
- Arbitration replaces the external select lines; the output is registered.
- Sits between multiple producer channels and one shared consumer.

Parameters:
- N, 4, number of input channels (N >= 2).
- W, 8, data width per channel in bits.
- CW (localparam), $clog2(N), width of the channel-index fields.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low. Assertion clears state immediately; release is synchronous to clk.
- in_valid  in  N  bit i: channel i presents data.
- in_data  in  N*W  channel i data in bits [i*W +: W].
- in_ready  out  N  bit i: channel i transfers this cycle when in_valid[i] is also high. Combinational.
- out_valid  out  1  output register holds a word.
- out_data  out  W  registered data word.
- out_ch  out  CW  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts out_data this cycle when out_valid is high.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_ch=0, last-grant pointer ptr=N-1, so channel 0 has first priority. in_ready=0 while rst_n=0.
- Load condition: load = !out_valid || out_ready.
- Arbitration (combinational):
  - When load=1 and any in_valid is high, grant g = first i with in_valid[i]=1, searching ptr+1, ptr+2, ... modulo N.
  - in_ready = one-hot(g) when load=1 and a request exists; otherwise all zero.
  - At most one in_ready bit is high per cycle.
- Transfer on a clk edge with load=1 and a request present:
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1, ptr <= g.
- Load=1 with no request: out_valid <= 0 and out_data/out_ch hold their values; ptr holds.
- Load=0 (out_valid=1, out_ready=0): output register, ptr and in_ready all frozen. in_ready=0.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- Simultaneous consume and refill: a new word loads in the same cycle the old word is consumed, with no bubble.
- Fairness:
  - With all N channels valid continuously, grants cycle 0,1,...,N-1,0,...
  - A channel that drops valid is skipped without losing a slot.
- Pointer wrap: ptr=N-1 searches from 0. ptr update is modulo N; the CW-bit arithmetic must not overrun when N is not a power of 2.
- Protocol rule: a producer holds in_valid and in_data stable until its in_ready is seen. The block does not check this.
- Reset mid-operation: any word held in the output register is discarded; ptr returns to N-1.

Optional Feature:
- Macro: RR_STREAM_MUX_FORCE_EN
- Defined: adds ports force_en (in 1) and force_sel (in CW).
  - While force_en=1, round-robin is bypassed and g=force_sel; this restores the legacy direct-select behaviour.
  - in_ready[force_sel] follows load; all other in_ready bits are 0.
  - ptr is not updated by forced transfers.
  - force_sel >= N grants nothing.
- Not defined: ports absent; pure round-robin.

Test Plan:
- Reset: hold rst_n=0 with in_valid=4'b1111 -> out_valid=0, out_ch=0, in_ready=0. Release rst_n, out_ready=1 -> first grant is ch0, then 1,2,3,0.
- Sparse requests: in_valid=4'b1010, out_ready=1 -> out_ch sequence 1,3,1,3; in_ready alternates 4'b0010/4'b1000.
- Backpressure: ch2 data 8'hA5 transferred, then out_ready=0 for 3 cycles -> out_data stays 8'hA5, in_ready=0 throughout. out_ready=1 -> next word loads in the same cycle.
- Idle drain: single word from ch0 (8'h3C), then in_valid=0 -> out_valid high 1 cycle, then 0; out_data still 8'h3C.
- Non-power-of-2: N=5, W=16, all valid -> out_ch 0,1,2,3,4,0; no index 5-7 is ever granted.
- Force (with RR_STREAM_MUX_FORCE_EN): force_en=1, force_sel=3, in_valid=4'b1111 -> out_ch=3 every cycle. Drop force_en -> round-robin resumes at the channel after the previous non-forced grant.
